// File: rtl/sd_sector_arbiter_pkg.sv
// Shared types and widths for the HPS sector-channel arbiter.
// Imported by the interface, the round-robin picker and the top.
package pc88_sd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_XFER,
        ST_DONE
    } sd_state_e;

    localparam int SD_LBA_W  = 32;
    localparam int SD_BYTE_W = 8;
    localparam int SD_WAIT_W = 25;

endpackage

// File: rtl/sd_sector_arbiter_if.sv
// Requester-side and hps_io-side signals of the sector arbiter as one bundle.
// master = the arbiter, slave = the disk controllers plus hps_io around it.
interface sd_sector_arbiter_if
    import pc88_sd_pkg::*;
#(
    parameter int NREQ = 4
);

    logic [NREQ*SD_LBA_W-1:0]  req_lba;
    logic [NREQ-1:0]           req_rd;
    logic [NREQ-1:0]           req_wr;
    logic [NREQ-1:0]           req_grant;
    logic [NREQ-1:0]           req_done;
    logic [NREQ-1:0]           req_err;
    logic [NREQ-1:0]           req_buff_wr;
    logic [NREQ*SD_BYTE_W-1:0] req_buff_din;

    logic [SD_LBA_W-1:0]       sd_lba;
    logic [NREQ-1:0]           sd_rd;
    logic [NREQ-1:0]           sd_wr;
    logic [NREQ-1:0]           sd_ack;
    logic                      sd_buff_wr;
    logic [SD_BYTE_W-1:0]      sd_buff_din;

    modport master (
        input  req_lba, req_rd, req_wr, req_buff_din, sd_ack, sd_buff_wr,
        output req_grant, req_done, req_err, req_buff_wr, sd_lba, sd_rd, sd_wr, sd_buff_din
    );

    modport slave (
        output req_lba, req_rd, req_wr, req_buff_din, sd_ack, sd_buff_wr,
        input  req_grant, req_done, req_err, req_buff_wr, sd_lba, sd_rd, sd_wr, sd_buff_din
    );

endinterface

// File: rtl/sd_sector_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first pending index after ptr_i,
// wrapping modulo N.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] pending_i,
    input  logic [W-1:0] ptr_i,
    output logic         valid_o,
    output logic [W-1:0] idx_o
);

    int j;

    // Scan farthest-to-nearest so the nearest pending index is written last.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        for (int k = N; k >= 1; k--) begin
            j = (int'(ptr_i) + k) % N;
            if (pending_i[j]) begin
                valid_o = 1'b1;
                idx_o   = W'(j);
            end
        end
    end

endmodule

// File: rtl/sd_sector_arbiter.sv
// Shares one hps_io sector channel between NREQ disk requesters, one sector
// transaction at a time, granted round-robin.
//   state    | meaning
//   ST_IDLE  | no owner; pick next pending requester, latch idx/op/lba
//   ST_ISSUE | owner's sd_rd/sd_wr strobe high, waiting for sd_ack
//   ST_XFER  | buffer traffic routed to owner until sd_ack falls
//   ST_DONE  | one-cycle req_done / req_err pulse, rr_ptr <= owner
module sd_sector_arbiter
    import pc88_sd_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 2**24
) (
    input  logic                clk_sys,
    input  logic                rstn,
    sd_sector_arbiter_if.master bus
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [SD_WAIT_W-1:0] WAIT_LAST = SD_WAIT_W'(TIMEOUT - 1);

    sd_state_e             state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  op_wr_q, op_wr_d;
    logic                  err_q, err_d;
    logic [SD_LBA_W-1:0]   lba_q, lba_d;
    logic [SD_WAIT_W-1:0]  wait_q, wait_d;
    logic                  old_ack_q;

    logic [NREQ-1:0]       pending;
    logic [NREQ-1:0]       owner_oh;
    logic                  owner_ack;
    logic                  pick_valid;
    logic [IDX_W-1:0]      pick_idx;

    assign pending   = bus.req_rd | bus.req_wr;
    assign owner_oh  = {{(NREQ-1){1'b0}}, 1'b1} << idx_q;
    assign owner_ack = bus.sd_ack[idx_q];

    rr_pick #(
        .N (NREQ),
        .W (IDX_W)
    ) u_rr_pick (
        .pending_i (pending),
        .ptr_i     (rr_ptr_q),
        .valid_o   (pick_valid),
        .idx_o     (pick_idx)
    );

    always_ff @(posedge clk_sys or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            rr_ptr_q  <= IDX_W'(NREQ - 1);
            op_wr_q   <= 1'b0;
            err_q     <= 1'b0;
            lba_q     <= '0;
            wait_q    <= '0;
            old_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rr_ptr_q  <= rr_ptr_d;
            op_wr_q   <= op_wr_d;
            err_q     <= err_d;
            lba_q     <= lba_d;
            wait_q    <= wait_d;
            old_ack_q <= owner_ack;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr_q;
        op_wr_d  = op_wr_q;
        err_d    = err_q;
        lba_d    = lba_q;
        wait_d   = (wait_q == '1) ? wait_q : wait_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                wait_d = '0;
                if (pick_valid) begin
                    state_d = ST_ISSUE;
                    idx_d   = pick_idx;
                    op_wr_d = bus.req_wr[pick_idx];
                    err_d   = 1'b0;
                    lba_d   = bus.req_lba[pick_idx*SD_LBA_W +: SD_LBA_W];
                end
            end
            ST_ISSUE: begin
                // Ack beats withdrawal, withdrawal beats timeout.
                if (owner_ack) begin
                    state_d = ST_XFER;
                end else if (!pending[idx_q]) begin
                    state_d = ST_IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end
            end
            ST_XFER: begin
                if (old_ack_q && !owner_ack) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                rr_ptr_d = idx_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.sd_lba      = lba_q;
    assign bus.req_grant   = (state_q != ST_IDLE) ? owner_oh : '0;
    assign bus.sd_rd       = (state_q == ST_ISSUE && !op_wr_q) ? owner_oh : '0;
    assign bus.sd_wr       = (state_q == ST_ISSUE &&  op_wr_q) ? owner_oh : '0;
    assign bus.req_done    = (state_q == ST_DONE && !err_q) ? owner_oh : '0;
    assign bus.req_err     = (state_q == ST_DONE &&  err_q) ? owner_oh : '0;
    assign bus.req_buff_wr = (state_q == ST_XFER && bus.sd_buff_wr) ? owner_oh : '0;
    assign bus.sd_buff_din = (state_q == ST_XFER) ?
                             bus.req_buff_din[idx_q*SD_BYTE_W +: SD_BYTE_W] : '0;

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Scoreboard bench for sd_sector_arbiter: a round-robin grant-order model feeds
// expected transactions to a monitor, while an hps_io model answers strobes.
`timescale 1ns/1ps
module tb_sd_sector_arbiter;
    import pc88_sd_pkg::*;

    localparam int NREQ = 4;
    localparam int TMO  = 16;

    typedef struct {
        int          idx;
        bit          op;
        logic [31:0] lba;
        bit          err;
        bit          wd;
        int          nrd;
        int          raise_cyc;
    } exp_t;

    // kind: 0 = ack and transfer, 1 = never ack, 2 = ack and hold until reset
    typedef struct {
        int kind;
        int delay;
        int nbytes;
        bit stray;
    } act_t;

    logic clk_sys = 1'b0;
    logic rstn    = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    sd_sector_arbiter_if #(.NREQ(NREQ)) bus ();

    sd_sector_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TMO)
    ) dut (
        .clk_sys (clk_sys),
        .rstn    (rstn),
        .bus     (bus.master)
    );

    exp_t exp_q[$];
    act_t act_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   last_win = NREQ - 1;
    bit   cur_valid = 1'b0;

    bit          t_op[NREQ];
    bit          t_both[NREQ];
    logic [31:0] t_lba[NREQ];
    act_t        t_act[NREQ];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
    endtask

    // Grant order from the rule: first pending index after the last winner.
    task automatic plan(input logic [NREQ-1:0] set, input int raise_c);
        logic [NREQ-1:0] rem;
        bit first;
        int w;
        rem   = set;
        first = 1'b1;
        while (rem != 0) begin
            w = -1;
            for (int k = 1; k <= NREQ; k++)
                if (w < 0 && rem[(last_win + k) % NREQ]) w = (last_win + k) % NREQ;
            exp_q.push_back('{idx: w, op: t_op[w], lba: t_lba[w],
                              err: (t_act[w].kind == 1), wd: 1'b0,
                              nrd: (t_act[w].kind == 0 && !t_op[w]) ? t_act[w].nbytes : 0,
                              raise_cyc: first ? raise_c : -1});
            act_q.push_back(t_act[w]);
            last_win = w;
            rem[w]   = 1'b0;
            first    = 1'b0;
        end
    endtask

    task automatic apply1(input int i);
        bus.req_lba[i*32 +: 32] = t_lba[i];
        bus.req_wr[i] = t_op[i];
        bus.req_rd[i] = !t_op[i] || t_both[i];
    endtask

    task automatic apply(input logic [NREQ-1:0] set);
        for (int i = 0; i < NREQ; i++) if (set[i]) apply1(i);
    endtask

    // Requesters drop their request on done/err; optional re-raise of rr_idx
    // once requester rr_when holds the grant.
    task automatic serve(input int n, input int rr_idx, input int rr_when);
        int got;
        int t;
        bit done_rr;
        got     = 0;
        t       = 0;
        done_rr = (rr_idx < 0);
        while (got < n && t < 6000) begin
            @(negedge clk_sys);
            t++;
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_done[i] || bus.req_err[i]) begin
                    bus.req_rd[i] = 1'b0;
                    bus.req_wr[i] = 1'b0;
                    got++;
                end
            end
            if (!done_rr) begin
                if (bus.req_grant[rr_when]) begin
                    apply1(rr_idx);
                    done_rr = 1'b1;
                end
            end
        end
        if (got < n) fail_now("serve_timeout");
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (t < 4000 && (exp_q.size() != 0 || act_q.size() != 0 || cur_valid ||
                            bus.req_grant != 0)) begin
            @(negedge clk_sys);
            t++;
        end
        if (t >= 4000) begin
            fail_now(name);
            exp_q.delete();
            act_q.delete();
        end
        @(negedge clk_sys);
    endtask

    initial begin : monitor
        exp_t            cur;
        int              start_cyc;
        int              bw_cnt;
        logic [NREQ-1:0] prev_strobe;
        logic [NREQ-1:0] strobe;
        logic [NREQ-1:0] oh;
        prev_strobe = '0;
        start_cyc   = 0;
        bw_cnt      = 0;
        oh          = '0;
        cur         = '{idx: 0, op: 1'b0, lba: '0, err: 1'b0, wd: 1'b0, nrd: 0, raise_cyc: -1};
        forever begin
            @(negedge clk_sys);
            if (!rstn) begin
                cur_valid   = 1'b0;
                prev_strobe = '0;
                continue;
            end
            strobe = bus.sd_rd | bus.sd_wr;
            if (strobe != 0 && prev_strobe == 0) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_grant");
                end else begin
                    cur = exp_q.pop_front();
                    oh  = NREQ'(1) << cur.idx;
                    check("strobe", {bus.sd_wr, bus.sd_rd},
                          cur.op ? {oh, {NREQ{1'b0}}} : {{NREQ{1'b0}}, oh});
                    check("grant", bus.req_grant, oh);
                    check("lba", bus.sd_lba, cur.lba);
                    if (cur.raise_cyc >= 0) check("latency", cyc - cur.raise_cyc, 1);
                    cur_valid = 1'b1;
                    start_cyc = cyc;
                    bw_cnt    = 0;
                end
            end
            if (cur_valid) begin
                if ((bus.req_buff_wr & ~oh) != 0) fail_now("buff_wr_non_owner");
                if (bus.req_buff_wr[cur.idx]) bw_cnt++;
                if (cur.wd && bus.req_grant == 0) cur_valid = 1'b0;
            end else if (bus.req_buff_wr != 0) begin
                fail_now("buff_wr_no_owner");
            end
            if ((bus.req_done | bus.req_err) != 0) begin
                if (!cur_valid || cur.wd) begin
                    fail_now("unexpected_pulse");
                end else begin
                    check("done", bus.req_done, cur.err ? '0 : oh);
                    check("err", bus.req_err, cur.err ? oh : '0);
                    check("buff_wr_count", bw_cnt, cur.nrd);
                    check("lba_hold", bus.sd_lba, cur.lba);
                    check("din_idle", bus.sd_buff_din, 0);
                    if (cur.err) check("timeout_len", cyc - start_cyc, TMO);
                    cur_valid = 1'b0;
                end
            end
            prev_strobe = strobe;
        end
    end

    initial begin : host
        act_t            a;
        int              idx;
        int              t;
        bit              op;
        logic [NREQ-1:0] strobe;
        bus.sd_ack     = '0;
        bus.sd_buff_wr = 1'b0;
        forever begin
            @(negedge clk_sys);
            strobe = bus.sd_rd | bus.sd_wr;
            if (!rstn || strobe == 0) continue;
            op  = |bus.sd_wr;
            idx = 0;
            for (int i = 0; i < NREQ; i++) if (strobe[i]) idx = i;
            if (act_q.size() == 0) begin
                fail_now("host_no_action");
                a = '{kind: 1, delay: 0, nbytes: 0, stray: 1'b0};
            end else begin
                a = act_q.pop_front();
            end
            case (a.kind)
                0: begin
                    repeat (a.delay) @(negedge clk_sys);
                    bus.sd_ack[idx] = 1'b1;
                    @(negedge clk_sys);
                    if (a.stray) bus.sd_ack[(idx + 1) % NREQ] = 1'b1;
                    for (int j = 0; j < a.nbytes; j++) begin
                        if (!op) begin
                            #2 bus.sd_buff_wr = 1'b1;
                            @(negedge clk_sys);
                            #2 bus.sd_buff_wr = 1'b0;
                            @(negedge clk_sys);
                        end else begin
                            check("sd_buff_din", bus.sd_buff_din, bus.req_buff_din[idx*8 +: 8]);
                            @(negedge clk_sys);
                        end
                    end
                    bus.sd_ack = '0;
                end
                1: begin
                    t = 0;
                    while (t < TMO + 8 && (bus.sd_rd | bus.sd_wr) != 0) begin
                        @(negedge clk_sys);
                        t++;
                    end
                end
                default: begin
                    @(negedge clk_sys);
                    bus.sd_ack[idx] = 1'b1;
                    t = 0;
                    while (rstn && t < 400) begin
                        @(negedge clk_sys);
                        t++;
                    end
                    bus.sd_ack = '0;
                end
            endcase
        end
    end

    initial begin : stimulus
        logic [NREQ-1:0] set;
        int              t;
        bus.req_lba      = '0;
        bus.req_rd       = '0;
        bus.req_wr       = '0;
        bus.req_buff_din = '0;
        for (int i = 0; i < NREQ; i++) begin
            t_op[i]   = 1'b0;
            t_both[i] = 1'b0;
            t_lba[i]  = '0;
            t_act[i]  = '{kind: 0, delay: 1, nbytes: 2, stray: 1'b0};
        end

        repeat (3) @(negedge clk_sys);
        check("reset_strobe", {bus.sd_wr, bus.sd_rd}, 0);
        check("reset_grant", bus.req_grant, 0);
        check("reset_lba", bus.sd_lba, 0);
        check("reset_misc", {bus.req_done, bus.req_err, bus.req_buff_wr, bus.sd_buff_din}, 0);
        rstn = 1'b1;
        @(negedge clk_sys);

        // Requesters 0 and 2 together straight after reset, 0 re-raised during 2.
        t_lba[0] = 32'h0000_1000;
        t_lba[2] = 32'h0000_2000;
        t_act[0] = '{kind: 0, delay: 2, nbytes: 3, stray: 1'b0};
        t_act[2] = '{kind: 0, delay: 1, nbytes: 4, stray: 1'b1};
        plan(4'b0101, cyc);
        apply(4'b0101);
        t_lba[0] = 32'h0000_1001;
        t_act[0] = '{kind: 0, delay: 0, nbytes: 2, stray: 1'b0};
        plan(4'b0001, -1);
        serve(3, 0, 2);
        wait_idle("idle_order");

        // Single read of a full sector.
        t_op[0]  = 1'b0;
        t_lba[0] = 32'h0000_0010;
        t_act[0] = '{kind: 0, delay: 5, nbytes: 512, stray: 1'b0};
        plan(4'b0001, cyc);
        apply(4'b0001);
        serve(1, -1, 0);
        wait_idle("idle_read512");

        // rd and wr both set: write wins; owner's byte reaches sd_buff_din.
        t_op[1]   = 1'b1;
        t_both[1] = 1'b1;
        t_lba[1]  = 32'hCAFE_0001;
        t_act[1]  = '{kind: 0, delay: 2, nbytes: 4, stray: 1'b0};
        bus.req_buff_din = 32'h3C_5A_A5_77;
        plan(4'b0010, cyc);
        apply(4'b0010);
        serve(1, -1, 0);
        wait_idle("idle_write");
        t_both[1] = 1'b0;

        // No ack: timeout error on requester 1.
        t_op[1]  = 1'b0;
        t_lba[1] = 32'h0000_0BAD;
        t_act[1] = '{kind: 1, delay: 0, nbytes: 0, stray: 1'b0};
        plan(4'b0010, cyc);
        apply(4'b0010);
        serve(1, -1, 0);
        wait_idle("idle_timeout");

        // Withdrawal in ISSUE: no pulse, round-robin pointer untouched.
        t_op[3]  = 1'b0;
        t_lba[3] = 32'h0003_0003;
        exp_q.push_back('{idx: 3, op: 1'b0, lba: t_lba[3], err: 1'b0, wd: 1'b1,
                          nrd: 0, raise_cyc: cyc});
        act_q.push_back('{kind: 1, delay: 0, nbytes: 0, stray: 1'b0});
        apply1(3);
        t = 0;
        while (t < 20 && !bus.sd_rd[3]) begin
            @(negedge clk_sys);
            t++;
        end
        if (t >= 20) fail_now("withdraw_no_strobe");
        repeat (3) @(negedge clk_sys);
        bus.req_rd[3] = 1'b0;
        @(negedge clk_sys);
        check("withdraw_strobe", bus.sd_rd, 0);
        check("withdraw_grant", bus.req_grant, 0);
        repeat (3) @(negedge clk_sys);
        wait_idle("idle_withdraw");

        for (int b = 0; b < 40; b++) begin
            set = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                t_lba[i]  = $urandom;
                t_both[i] = ($urandom_range(0, 3) == 0);
                t_op[i]   = t_both[i] | 1'($urandom_range(0, 1));
                t_act[i]  = '{kind: ($urandom_range(0, 7) == 0) ? 1 : 0,
                              delay: $urandom_range(0, 6),
                              nbytes: $urandom_range(1, 16),
                              stray: 1'($urandom_range(0, 1))};
            end
            bus.req_buff_din = $urandom;
            plan(set, cyc);
            apply(set);
            serve($countones(set), -1, 0);
            wait_idle("idle_random");
        end

        // Reset in XFER: outputs clear at once, held request re-granted after.
        t_op[0]  = 1'b0;
        t_lba[0] = 32'h0BAD_F00D;
        t_act[0] = '{kind: 2, delay: 0, nbytes: 0, stray: 1'b0};
        plan(4'b0001, cyc);
        apply(4'b0001);
        t = 0;
        while (t < 50 && !bus.sd_ack[0]) begin
            @(negedge clk_sys);
            t++;
        end
        if (t >= 50) fail_now("reset_no_ack");
        repeat (3) @(negedge clk_sys);
        #2 rstn = 1'b0;
        #1;
        check("rst_strobe", {bus.sd_wr, bus.sd_rd}, 0);
        check("rst_grant", bus.req_grant, 0);
        check("rst_lba", bus.sd_lba, 0);
        check("rst_misc", {bus.req_done, bus.req_err, bus.req_buff_wr, bus.sd_buff_din}, 0);
        @(negedge clk_sys);
        @(negedge clk_sys);
        last_win = NREQ - 1;
        t_act[0] = '{kind: 0, delay: 1, nbytes: 3, stray: 1'b0};
        plan(4'b0001, cyc);
        rstn = 1'b1;
        serve(1, -1, 0);
        wait_idle("idle_after_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
